mmio_timer_responder: RTL

//  Memory-mapped timer peripheral; responder on the CPU data-memory port (address/readEnable/writeEnable/writeData/readData).

---
 rtl/mmio_timer_defs.sv | 14 +
 rtl/mmio_timer_prescaler.sv | 18 +
 rtl/mmio_timer_responder.sv | 100 ++++++++++
 3 files changed

// File: rtl/mmio_timer_defs.sv
// mmio_timer_defs: register offsets and CTRL/STATUS bit positions shared by the timer peripheral
package mmio_timer_defs;
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;
    localparam logic [2:0] OFF_CAPTURE  = 3'd5;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_AR    = 1;
    localparam int CTRL_IRQEN = 2;
    localparam int STAT_MATCH = 0;
    localparam int STAT_CAP   = 1;
endpackage

// File: rtl/mmio_timer_prescaler.sv
// mmio_timer_prescaler: emits a one-cycle tick every limit+1 enabled cycles; clear restarts the count
module mmio_timer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] limit,
    input  logic        clear,
    output logic        tick
);
    logic [31:0] psc;
    assign tick = enable && (psc == limit);
    always_ff @(posedge clk) begin
        if (rst || clear)
            psc <= '0;
        else if (enable)
            psc <= tick ? '0 : psc + 32'd1;
    end
endmodule

// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: memory-mapped prescaled timer with compare match and level irq.
// Optional input capture is built only when MMIO_TIMER_CAPTURE_EN is defined.
module mmio_timer_responder
    import mmio_timer_defs::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] RESET_PRESC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        readEnable,
    input  logic        writeEnable,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    input  logic        captureIn,
    output logic        irq
);
    logic        hit, wr, tick, match, mflag, cflag;
    logic [2:0]  off, ctrl;
    logic [1:0]  w1c;
    logic [31:0] presc, count, compare, capture, mux;
    logic [1:0]  unused_addr;

    assign unused_addr = address[1:0];
    assign hit   = address[31:5] == BASE_ADDR[31:5];
    assign off   = address[4:2];
    assign wr    = writeEnable && hit;
    assign w1c   = (wr && off == OFF_STATUS) ? writeData[1:0] : 2'b00;
    assign match = tick && count == compare;
    assign irq   = ctrl[CTRL_IRQEN] & (mflag | cflag);

    mmio_timer_prescaler u_psc (
        .clk   (clk),
        .rst   (rst),
        .enable(ctrl[CTRL_EN]),
        .limit (presc),
        .clear (wr && off == OFF_PRESCALE),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= '0;
            presc   <= RESET_PRESC;
            count   <= '0;
            compare <= '1;
            mflag   <= 1'b0;
        end else begin
            if (wr && off == OFF_CTRL)
                ctrl <= writeData[2:0];
            if (wr && off == OFF_PRESCALE)
                presc <= writeData;
            if (wr && off == OFF_COMPARE)
                compare <= writeData;
            if (wr && off == OFF_COUNT)
                count <= writeData;
            else if (tick)
                count <= (match && ctrl[CTRL_AR]) ? '0 : count + 32'd1;
            // a match in the same cycle as its W1C keeps the flag set
            mflag <= match | (mflag & ~w1c[STAT_MATCH]);
        end
    end

`ifdef MMIO_TIMER_CAPTURE_EN
    logic [2:0] cap_sync;
    logic       cap_edge;
    assign cap_edge = cap_sync[1] & ~cap_sync[2];
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sync <= '0;
            capture  <= '0;
            cflag    <= 1'b0;
        end else begin
            cap_sync <= {cap_sync[1:0], captureIn};
            if (cap_edge)
                capture <= count;
            cflag <= cap_edge | (cflag & ~w1c[STAT_CAP]);
        end
    end
`else
    logic unused_cap;
    assign unused_cap = captureIn;
    assign capture    = '0;
    assign cflag      = 1'b0;
`endif

    always_comb begin
        case (off)
            OFF_CTRL:     mux = {29'd0, ctrl};
            OFF_PRESCALE: mux = presc;
            OFF_COUNT:    mux = count;
            OFF_COMPARE:  mux = compare;
            OFF_STATUS:   mux = {30'd0, cflag, mflag};
            OFF_CAPTURE:  mux = capture;
            default:      mux = '0;
        endcase
        readData = (readEnable && hit) ? mux : '0;
    end
endmodule
